// File: rtl/ice40_pll_sequencer.sv
// ice40_pll_sequencer
// Control-side sequencer for an iCE40 SB_PLL40_CORE. Holds the PLL in reset,
// releases it, waits for LOCK, qualifies it over a stable window and only
// then drops BYPASS and raises `locked`. Lock timeouts trigger a bounded
// number of retries before the sequencer parks in a latched fault state.
// Everything runs on the PLL reference clock; LOCK is resynchronized first.
module ice40_pll_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       relock,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       locked,
    output logic       fault,
    output logic [1:0] retry_count
);

    // One shared cycle counter, wide enough for the longest interval.
    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    // Terminal counts: the counter starts at 0 on state entry, so the exit
    // edge is the one where it already holds N-1.
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    // Registered PLL control / status outputs, updated together with the
    // state so they are always the Moore decode of the current state.
    typedef struct packed {
        logic resetb;
        logic bypass;
        logic locked;
        logic fault;
    } ctrl_t;

    // Output decode for a given state; used when loading ctrl_reg alongside
    // every state_reg load.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '{resetb: 1'b0, bypass: 1'b1, locked: 1'b0, fault: 1'b0};
        case (s)
            ST_HOLD:      c = '{resetb: 1'b0, bypass: 1'b1, locked: 1'b0, fault: 1'b0};
            ST_WAIT_LOCK: c = '{resetb: 1'b1, bypass: 1'b1, locked: 1'b0, fault: 1'b0};
            ST_SETTLE:    c = '{resetb: 1'b1, bypass: 1'b1, locked: 1'b0, fault: 1'b0};
            ST_LOCKED:    c = '{resetb: 1'b1, bypass: 1'b0, locked: 1'b1, fault: 1'b0};
            ST_FAULT:     c = '{resetb: 1'b0, bypass: 1'b1, locked: 1'b0, fault: 1'b1};
            default:      c = '{resetb: 1'b0, bypass: 1'b1, locked: 1'b0, fault: 1'b0};
        endcase
        return c;
    endfunction

    logic [1:0]       sync_reg;
    logic             lock_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       retry_reg;
    ctrl_t            ctrl_reg;

    // Two-flop synchronizer for the PLL LOCK output (asynchronous to clk).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_lock};
        end
    end

    assign lock_s = sync_reg[1];

    // Sequencer FSM: state, shared counter, retry count and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            retry_reg <= 2'd0;
            ctrl_reg  <= decode(ST_HOLD);
        end else if (relock) begin
            // Restart request outranks every other transition, including
            // restarting an in-progress HOLD from zero.
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            retry_reg <= 2'd0;
            ctrl_reg  <= decode(ST_HOLD);
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg <= ST_WAIT_LOCK;
                        ctrl_reg  <= decode(ST_WAIT_LOCK);
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a coincident timeout.
                    if (lock_s) begin
                        state_reg <= ST_SETTLE;
                        ctrl_reg  <= decode(ST_SETTLE);
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg <= '0;
                        if (retry_reg == RETRY_LIMIT) begin
                            state_reg <= ST_FAULT;
                            ctrl_reg  <= decode(ST_FAULT);
                        end else begin
                            // Never exceeds RETRY_LIMIT: the limit case above
                            // goes to FAULT without incrementing.
                            retry_reg <= retry_reg + 2'd1;
                            state_reg <= ST_HOLD;
                            ctrl_reg  <= decode(ST_HOLD);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                ST_SETTLE: begin
                    // A dropout sends us back with a fresh timeout window but
                    // is not charged as a retry.
                    if (!lock_s) begin
                        state_reg <= ST_WAIT_LOCK;
                        ctrl_reg  <= decode(ST_WAIT_LOCK);
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg <= ST_LOCKED;
                        ctrl_reg  <= decode(ST_LOCKED);
                        cnt_reg   <= '0;
                        retry_reg <= 2'd0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                ST_LOCKED: begin
                    // Loss of lock re-runs the full sequence without counting
                    // against the retry budget.
                    if (!lock_s) begin
                        state_reg <= ST_HOLD;
                        ctrl_reg  <= decode(ST_HOLD);
                        cnt_reg   <= '0;
                    end
                end

                ST_FAULT: begin
                    // Latched until relock or reset.
                end

                default: begin
                    state_reg <= ST_HOLD;
                    ctrl_reg  <= decode(ST_HOLD);
                    cnt_reg   <= '0;
                    retry_reg <= 2'd0;
                end
            endcase
        end
    end

    assign pll_resetb  = ctrl_reg.resetb;
    assign pll_bypass  = ctrl_reg.bypass;
    assign locked      = ctrl_reg.locked;
    assign fault       = ctrl_reg.fault;
    assign retry_count = retry_reg;

endmodule

// File: tb/tb_ice40_pll_sequencer.sv
// Testbench for ice40_pll_sequencer. Stimulus schedules expected output
// vectors against a per-sequence edge number; a monitor pops and checks them
// 1 ns after each clock edge (or after a reset assertion).
module tb_ice40_pll_sequencer;

    logic       clk;
    logic       reset;
    logic       relock;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       locked;
    logic       fault;
    logic [1:0] retry_count;

    // Expected {pll_resetb, pll_bypass, locked, fault} per state.
    localparam logic [3:0] O_HOLD  = 4'b0100;
    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_LOCK  = 4'b1010;
    localparam logic [3:0] O_FAULT = 4'b0101;

    typedef struct {
        int         edge_no;
        string      name;
        logic [5:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    ice40_pll_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .relock     (relock),
        .pll_lock   (pll_lock),
        .pll_resetb (pll_resetb),
        .pll_bypass (pll_bypass),
        .locked     (locked),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Schedule an expectation: outputs after edge e (e=0: right after reset asserts).
    task automatic expect_at(input int e, input string nm, input logic [3:0] o, input logic [1:0] rc);
        exp_t x;
        x.edge_no = e;
        x.name    = nm;
        x.val     = {o, rc};
        exp_q.push_back(x);
    endtask

    // Return at the falling edge following edge n of the current sequence.
    task automatic after_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL wait_edge: stuck at edge %0d, required edge %0d", edge_cnt, n);
        end
    endtask

    // Assert reset at a falling edge (checked immediately), then release.
    task automatic restart(input string nm);
        pll_lock = 1'b0;
        relock   = 1'b0;
        expect_at(0, nm, O_HOLD, 2'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for the monitor to consume every scheduled check.
    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: check for edge %0d never reached (now edge %0d)", x.name, x.edge_no, edge_cnt);
        end
    endtask

    // Monitor: track edge number, compare outputs against the queue head.
    initial begin : monitor
        exp_t       x;
        logic [5:0] act;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) edge_cnt = 0;
            else       edge_cnt = edge_cnt + 1;
            #1;
            while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
                x   = exp_q.pop_front();
                act = {pll_resetb, pll_bypass, locked, fault, retry_count};
                checks++;
                if (x.edge_no < edge_cnt) begin
                    errors++;
                    $display("FAIL %s: check for edge %0d skipped (now edge %0d)", x.name, x.edge_no, edge_cnt);
                end else if (act !== x.val) begin
                    errors++;
                    $display("FAIL %s @edge %0d: rb/bp/lk/ft/rc got %b required %b", x.name, edge_cnt, act, x.val);
                end else begin
                    $display("ok   %s @edge %0d: rb/bp/lk/ft/rc = %b", x.name, edge_cnt, act);
                end
            end
        end
    end

    // Stimulus.
    initial begin : stimulus
        reset    = 1'b0;
        relock   = 1'b0;
        pll_lock = 1'b0;
        #1;

        // Nominal lock: pll_lock sampled high at edge 10.
        restart("reset_state");
        expect_at(3,  "hold_edge3",       O_HOLD, 2'd0);
        expect_at(4,  "resetb_rise",      O_RUN,  2'd0);
        expect_at(19, "settle_edge19",    O_RUN,  2'd0);
        expect_at(20, "nominal_locked",   O_LOCK, 2'd0);
        expect_at(30, "nominal_hold",     O_LOCK, 2'd0);
        after_edge(9);
        pll_lock = 1'b1;
        drain();

        // Glitch in SETTLE, then loss of lock from LOCKED.
        restart("reset_glitch");
        expect_at(16, "glitch_back_wait", O_RUN,  2'd0);
        expect_at(17, "glitch_resettle",  O_RUN,  2'd0);
        expect_at(20, "glitch_no_lock20", O_RUN,  2'd0);
        expect_at(24, "glitch_no_lock24", O_RUN,  2'd0);
        expect_at(25, "glitch_locked25",  O_LOCK, 2'd0);
        expect_at(31, "lol_still_locked", O_LOCK, 2'd0);
        expect_at(32, "lol_to_hold",      O_HOLD, 2'd0);
        expect_at(36, "lol_rehold_done",  O_RUN,  2'd0);
        after_edge(9);
        pll_lock = 1'b1;
        after_edge(13);
        pll_lock = 1'b0;
        after_edge(14);
        pll_lock = 1'b1;
        after_edge(29);
        pll_lock = 1'b0;
        drain();

        // Fault after retries, persistence, relock recovery, async reset.
        restart("reset_fault");
        expect_at(35,  "t1_before_timeout", O_RUN,   2'd0);
        expect_at(36,  "t1_timeout",        O_HOLD,  2'd1);
        expect_at(40,  "t2_wait",           O_RUN,   2'd1);
        expect_at(71,  "t2_before_timeout", O_RUN,   2'd1);
        expect_at(72,  "t2_timeout",        O_HOLD,  2'd2);
        expect_at(107, "t3_before_timeout", O_RUN,   2'd2);
        expect_at(108, "fault_entry",       O_FAULT, 2'd2);
        expect_at(308, "fault_persist",     O_FAULT, 2'd2);
        expect_at(311, "relock_clear",      O_HOLD,  2'd0);
        expect_at(314, "relock_hold",       O_HOLD,  2'd0);
        expect_at(315, "relock_wait",       O_RUN,   2'd0);
        expect_at(329, "recover_settle",    O_RUN,   2'd0);
        expect_at(330, "recover_locked",    O_LOCK,  2'd0);
        expect_at(335, "pre_async_locked",  O_LOCK,  2'd0);
        after_edge(310);
        relock = 1'b1;
        after_edge(311);
        relock = 1'b0;
        after_edge(319);
        pll_lock = 1'b1;
        after_edge(335);
        #2;
        expect_at(0, "async_reset_from_locked", O_HOLD, 2'd0);
        reset = 1'b1;
        drain();
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case a wait above never resolves.
    initial begin : watchdog
        #60000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
        $fatal(1, "time limit");
    end

endmodule
